pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
Parametrised next-generation program-counter unit for the RV32I core. It generates the fetch address with a valid/ready handshake toward instruction fetch, and applies redirects from execute (branch, jump, trap) with stall override. It detects misaligned targets and vectors them to the trap address. It also holds a small return-address stack (RAS) for call/return prediction.

Parameters:
XLEN, 32, address/data width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect
STEP, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC, no sequential advance
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is a valid fetch request
pc_ready  in  1  fetch accepts pc this cycle
redirect_valid  in  1  apply redirect this cycle
redirect_sel  in  2  00 reserved (treated as trap), 01 branch, 10 jump, 11 trap
redirect_base  in  XLEN  PC of the redirecting instruction
redirect_imm  in  XLEN  branch offset, sign-extended
redirect_target  in  XLEN  absolute jump target (JALR result)
misalign  out  1  one-cycle pulse: redirect target misaligned
badaddr  out  XLEN  last misaligned target captured
ras_push  in  1  push ras_push_addr
ras_push_addr  in  XLEN  return address to push
ras_pop  in  1  pop top entry
ras_top  out  XLEN  current top of stack, 0 when empty
ras_empty  out  1  stack holds no entries

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_VECTOR, pc_valid=0, misalign=0, badaddr=0, RAS count=0, ras_empty=1, ras_top=0. Reset overrides every other input, including mid-redirect or mid-push.
- pc_valid goes to 1 at the first edge with rst=0 and stays 1 until the next reset.
- Next-PC priority, highest first:
  1. rst.
  2. redirect_valid. Applied even when stall=1 or pc_ready=0, so a fetch in flight is squashed.
  3. Sequential advance: pc <= pc + STEP when pc_valid & pc_ready & !stall.
  4. Hold.
- Redirect target:
  - branch: redirect_base + redirect_imm.
  - jump: redirect_target with bit 0 cleared.
  - trap/reserved: TRAP_VECTOR.
- Misalignment: if a branch/jump target has bits[1:0] != 0, the unit loads pc <= TRAP_VECTOR, pulses misalign for one cycle, and sets badaddr <= the offending target. Trap targets are never checked.
- All address arithmetic is modulo 2^XLEN with no saturation. 32'hFFFF_FFFC + 4 yields 0.
- Latency: new pc is visible the cycle after the qualifying edge. No combinational path from inputs to pc.
- RAS storage is a circular buffer with write pointer wp and a count.
  - Push only: entry[wp] <= addr, wp++ (wraps). Count saturates at RAS_DEPTH; on overflow the oldest entry is silently overwritten.
  - Pop only: if count>0, wp--, count--. Pop on empty is ignored; state is unchanged.
  - Push and pop together: overwrite the top entry (entry[wp-1]) with addr; count unchanged. If empty, treat as push only.
  - ras_top = entry[wp-1] when count>0, else 0. ras_empty = (count==0). Both outputs are registered-state derived.
- RAS operations are independent of stall and redirect.

Test Plan:
- Reset then release, pc_ready=1, stall=0 -> pc 0,0,4,8 with pc_valid 0→1 one edge after release; pc holds 0 while pc_ready=0.
- pc=0x40, redirect branch base=0x20, imm=0xFFFF_FFF0, stall=1 -> next pc=0x10; misalign=0.
- Redirect jump target=0x0000_1003 -> pc=TRAP_VECTOR (0x100), misalign pulse 1 cycle, badaddr=0x1003; with target=0x1001 -> pc=0x1000, no misalign.
- pc=0xFFFF_FFFC, pc_ready=1 -> pc=0x0000_0000; redirect_sel=00 -> pc=0x100.
- RAS_DEPTH=4: push A,B,C,D,E -> ras_top=E; 4 pops yield E,D,C,B, then ras_empty=1; 5th pop leaves ras_top=0 with no state change.
- Push+pop same cycle with top=B -> top becomes new addr and count unchanged; rst asserted during a redirect -> pc=RESET_VECTOR, RAS empty.

Source files
------------

// File: rtl/pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_unit
// Brief    : RV32I fetch PC generator with redirect/trap handling, misaligned
//            target detection and a circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              STEP         = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_sel,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_imm,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misalign,
    output logic [XLEN-1:0] badaddr,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty
);

    localparam int c_ptr_w = $clog2(RAS_DEPTH);

    logic [XLEN-1:0]    r_pc;
    logic               r_pc_valid;
    logic               r_misalign;
    logic [XLEN-1:0]    r_badaddr;

    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_wp;
    logic [c_ptr_w:0]   r_count;

    logic [XLEN-1:0]    w_branch_tgt;
    logic [XLEN-1:0]    w_tgt;
    logic [XLEN-1:0]    w_bad_src;
    logic               w_check;
    logic               w_mis;
    logic [c_ptr_w-1:0] w_top_idx;
    logic               w_empty;
    logic               w_full;

    assign w_branch_tgt = redirect_base + redirect_imm;

    // Jumps report the raw JALR result as the bad address, before bit 0 is cleared.
    always_comb begin
        w_tgt     = TRAP_VECTOR;
        w_bad_src = redirect_target;
        w_check   = 1'b0;
        case (redirect_sel)
            2'b01: begin
                w_tgt     = w_branch_tgt;
                w_bad_src = w_branch_tgt;
                w_check   = 1'b1;
            end
            2'b10: begin
                w_tgt     = {redirect_target[XLEN-1:1], 1'b0};
                w_bad_src = redirect_target;
                w_check   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_mis = w_check && (w_tgt[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_VECTOR;
            r_pc_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_badaddr  <= '0;
        end else begin
            r_pc_valid <= 1'b1;
            r_misalign <= 1'b0;
            if (redirect_valid) begin
                if (w_mis) begin
                    r_pc       <= TRAP_VECTOR;
                    r_misalign <= 1'b1;
                    r_badaddr  <= w_bad_src;
                end else begin
                    r_pc <= w_tgt;
                end
            end else if (r_pc_valid && pc_ready && !stall) begin
                r_pc <= r_pc + XLEN'(STEP);
            end
        end
    end

    assign w_top_idx = r_wp - c_ptr_w'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (c_ptr_w + 1)'(RAS_DEPTH));

    // A combined push+pop on a non-empty stack replaces the top in place.
    always_ff @(posedge clk) begin
        if (!rst && ras_push) begin
            if (ras_pop && !w_empty) begin
                r_ras[w_top_idx] <= ras_push_addr;
            end else begin
                r_ras[r_wp] <= ras_push_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_count <= '0;
        end else begin
            case ({ras_push, ras_pop})
                2'b10: begin
                    r_wp <= r_wp + c_ptr_w'(1);
                    if (!w_full) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                2'b01: begin
                    if (!w_empty) begin
                        r_wp    <= r_wp - c_ptr_w'(1);
                        r_count <= r_count - 1'b1;
                    end
                end
                2'b11: begin
                    if (w_empty) begin
                        r_wp    <= r_wp + c_ptr_w'(1);
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign misalign  = r_misalign;
    assign badaddr   = r_badaddr;
    assign ras_top   = w_empty ? '0 : r_ras[w_top_idx];
    assign ras_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen_unit
// Brief    : Directed vector table for PC sequencing/redirects plus RAS sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic [31:0] redirect_target;
    logic        misalign;
    logic [31:0] badaddr;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_ready        (pc_ready),
        .redirect_valid  (redirect_valid),
        .redirect_sel    (redirect_sel),
        .redirect_base   (redirect_base),
        .redirect_imm    (redirect_imm),
        .redirect_target (redirect_target),
        .misalign        (misalign),
        .badaddr         (badaddr),
        .ras_push        (ras_push),
        .ras_push_addr   (ras_push_addr),
        .ras_pop         (ras_pop),
        .ras_top         (ras_top),
        .ras_empty       (ras_empty)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        ready;
        logic        rv;
        logic [1:0]  sel;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_mis;
        logic [31:0] e_bad;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ras_op(input logic r, input logic pu, input logic po, input logic [31:0] a,
                          input logic [31:0] e_top, input logic e_empty, input string nm);
        rst           = r;
        ras_push      = pu;
        ras_pop       = po;
        ras_push_addr = a;
        step();
        chk({nm, "_top"}, ras_top, e_top);
        chk({nm, "_empty"}, {31'd0, ras_empty}, {31'd0, e_empty});
    endtask

    initial begin
        //           rst  stl  rdy  rv   sel    base          imm           tgt           e_pc          vld  mis  e_bad
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0000,1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,1'b1,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0000,1'b0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0000,1'b1,1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0000,1'b1,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0004,1'b1,1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0008,1'b1,1'b0,32'h0};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0008,1'b1,1'b0,32'h0};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,2'b10,32'h0,        32'h0,        32'h0000_0040,32'h0000_0040,1'b1,1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,2'b01,32'h20,       32'hFFFF_FFF0,32'h0,        32'h0000_0010,1'b1,1'b0,32'h0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,2'b10,32'h0,        32'h0,        32'h0000_1003,32'h0000_0100,1'b1,1'b1,32'h0000_1003};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0100,1'b1,1'b0,32'h0000_1003};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b1,2'b10,32'h0,        32'h0,        32'h0000_1001,32'h0000_1000,1'b1,1'b0,32'h0000_1003};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b1,2'b10,32'h0,        32'h0,        32'hFFFF_FFFC,32'hFFFF_FFFC,1'b1,1'b0,32'h0000_1003};
        vecs[13] = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0000,1'b1,1'b0,32'h0000_1003};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b1,2'b00,32'h0000_0800,32'h4,        32'h0000_2000,32'h0000_0100,1'b1,1'b0,32'h0000_1003};
        vecs[15] = '{1'b0,1'b0,1'b1,1'b1,2'b01,32'h0000_0100,32'h2,        32'h0,        32'h0000_0100,1'b1,1'b1,32'h0000_0102};
        vecs[16] = '{1'b0,1'b0,1'b1,1'b1,2'b11,32'h0000_0003,32'h1,        32'h0000_0003,32'h0000_0100,1'b1,1'b0,32'h0000_0102};
        vecs[17] = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0000_0104,1'b1,1'b0,32'h0000_0102};
        vecs[18] = '{1'b0,1'b0,1'b1,1'b1,2'b01,32'h0000_0200,32'h10,       32'h0,        32'h0000_0210,1'b1,1'b0,32'h0000_0102};
        vecs[19] = '{1'b1,1'b0,1'b1,1'b1,2'b10,32'h0,        32'h0,        32'h0000_3000,32'h0000_0000,1'b0,1'b0,32'h0};

        rst = 1'b1; stall = 1'b0; pc_ready = 1'b0;
        redirect_valid = 1'b0; redirect_sel = 2'b00;
        redirect_base = '0; redirect_imm = '0; redirect_target = '0;
        ras_push = 1'b0; ras_pop = 1'b0; ras_push_addr = '0;

        for (int i = 0; i < NV; i++) begin
            rst             = vecs[i].rst;
            stall           = vecs[i].stall;
            pc_ready        = vecs[i].ready;
            redirect_valid  = vecs[i].rv;
            redirect_sel    = vecs[i].sel;
            redirect_base   = vecs[i].base;
            redirect_imm    = vecs[i].imm;
            redirect_target = vecs[i].tgt;
            step();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'd0, pc_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_badaddr", i), badaddr, vecs[i].e_bad);
        end

        redirect_valid = 1'b0;
        pc_ready       = 1'b0;
        chk("reset_ras_empty", {31'd0, ras_empty}, 32'd1);
        chk("reset_ras_top", ras_top, 32'd0);

        // Overflow: A is overwritten by E, so pops walk E, D, C, B.
        ras_op(1'b0, 1'b1, 1'b0, 32'hA, 32'hA, 1'b0, "push_a");
        ras_op(1'b0, 1'b1, 1'b0, 32'hB, 32'hB, 1'b0, "push_b");
        ras_op(1'b0, 1'b1, 1'b0, 32'hC, 32'hC, 1'b0, "push_c");
        ras_op(1'b0, 1'b1, 1'b0, 32'hD, 32'hD, 1'b0, "push_d");
        ras_op(1'b0, 1'b1, 1'b0, 32'hE, 32'hE, 1'b0, "push_e");
        ras_op(1'b0, 1'b0, 1'b1, 32'h0, 32'hD, 1'b0, "pop1");
        ras_op(1'b0, 1'b0, 1'b1, 32'h0, 32'hC, 1'b0, "pop2");
        ras_op(1'b0, 1'b0, 1'b1, 32'h0, 32'hB, 1'b0, "pop3");
        ras_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, "pop4");
        ras_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, "pop_empty");

        ras_op(1'b0, 1'b1, 1'b0, 32'hA, 32'hA, 1'b0, "re_push_a");
        ras_op(1'b0, 1'b1, 1'b0, 32'hB, 32'hB, 1'b0, "re_push_b");
        ras_op(1'b0, 1'b1, 1'b1, 32'h55, 32'h55, 1'b0, "pushpop");
        ras_op(1'b0, 1'b0, 1'b1, 32'h0, 32'hA, 1'b0, "pop_after_pp");
        ras_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, "pop_after_pp2");
        ras_op(1'b0, 1'b1, 1'b1, 32'h77, 32'h77, 1'b0, "pushpop_empty");

        redirect_valid  = 1'b1;
        redirect_sel    = 2'b10;
        redirect_target = 32'h0000_4000;
        ras_op(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 1'b1, "rst_mid_push");
        chk("rst_mid_redirect_pc", pc, 32'h0);
        chk("rst_mid_redirect_valid", {31'd0, pc_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
